// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one difference bit per RUN cycle, LSB first, result registered on DONE.
// Latency WIDTH+1 edges to done; start is only taken in IDLE and never queued.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;

  logic w_ai, w_bi, w_d, w_br_nxt, w_last;

  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_d      = w_ai ^ w_bi ^ r_br;
  assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == S_IDLE);
    done  = (r_state == S_DONE);
  end

  // Difference bits shift into the vacated top of r_a, so after the last bit it holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a  <= {w_d, r_a[WIDTH-1:1]};
          r_b  <= {1'b0, r_b[WIDTH-1:1]};
          r_br <= w_br_nxt;
          if (w_last) begin
            diff <= {w_d, r_a[WIDTH-1:1]};
            bout <= w_br_nxt;
            ovf  <= r_br ^ w_br_nxt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 instance for latency/protocol/corner cases, WIDTH=2 for exhaustive.
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, done8, bout8, ovf8;
  logic [7:0] diff8;
  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready2, done2, bout2, ovf2;
  logic [1:0] diff2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .ready(ready2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2));

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [9:0] model(int w, longint av, longint bv, longint bi);
    longint m, r, sa, sb, sr;
    logic [7:0] d;
    logic bo, ov;
    m  = longint'(1) << w;
    r  = av - bv - bi;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    sr = sa - sb - bi;
    d  = 8'((r + 2 * m) % m);
    bo = (r < 0);
    ov = (sr < -(m / 2)) || (sr > (m / 2) - 1);
    return {bo, ov, d};
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int n);
    int g = 0;
    while (!ready8 && g < 30) begin @(posedge clk); #1; g++; end
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    n = 0;
    while (!done8 && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi, output int n);
    int g = 0;
    while (!ready2 && g < 30) begin @(posedge clk); #1; g++; end
    a2 = a; b2 = b; bin2 = bi; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
    n = 0;
    while (!done2 && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    int n;
    #12 rst_n = 1'b1;
    op8(8'h00, 8'h01, 1'b0, n);
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (ready8 !== 1'b1) $display("FAIL reset_ready got %b want 1", ready8); else n_pass++;
    n_total++; if (done8 !== 1'b0) $display("FAIL reset_done got %b want 0", done8); else n_pass++;
    n_total++; if ({diff8, bout8, ovf8} !== 10'h0) $display("FAIL reset_outputs got %h/%b/%b want 00/0/0", diff8, bout8, ovf8); else n_pass++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    op8(8'h05, 8'h03, 1'b0, n);
    n_total++; if (n !== 8) $display("FAIL basic_latency got %0d want 8", n); else n_pass++;
    n_total++; if ({diff8, bout8, ovf8} !== {8'h02, 2'b00}) $display("FAIL basic_result got %h/%b/%b want 02/0/0", diff8, bout8, ovf8); else n_pass++;
    n_total++; if (ready8 !== 1'b0) $display("FAIL basic_ready_at_done got %b want 0", ready8); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({ready8, done8} !== 2'b10) $display("FAIL basic_ready_after got %b%b want 10", ready8, done8); else n_pass++;
  endtask

  task automatic test_corners();
    logic [16:0] tbl [4] = '{{8'h00, 8'h01, 1'b0}, {8'h80, 8'h01, 1'b0}, {8'h7F, 8'hFF, 1'b0}, {8'h00, 8'h00, 1'b1}};
    logic [9:0] want [4] = '{{1'b1, 1'b0, 8'hFF}, {1'b0, 1'b1, 8'h7F}, {1'b1, 1'b1, 8'h80}, {1'b1, 1'b0, 8'hFF}};
    int n;
    for (int i = 0; i < 4; i++) begin
      op8(tbl[i][16:9], tbl[i][8:1], tbl[i][0], n);
      n_total++;
      if ({bout8, ovf8, diff8} !== want[i] || n !== 8)
        $display("FAIL corner%0d got %b/%b/%h lat %0d want %b/%b/%h lat 8", i, bout8, ovf8, diff8, n, want[i][9], want[i][8], want[i][7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic bi;
    logic [9:0] e;
    int n;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      e = model(8, longint'(a), longint'(b), longint'(bi));
      op8(a, b, bi, n);
      n_total++;
      if ({bout8, ovf8, diff8} !== e || n !== 8)
        $display("FAIL random %h-%h-%b got %b/%b/%h lat %0d want %b/%b/%h", a, b, bi, bout8, ovf8, diff8, n, e[9], e[8], e[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_exhaustive_w2();
    logic [9:0] e;
    logic [1:0] a, b;
    logic bi;
    int n;
    for (int i = 0; i < 32; i++) begin
      a = 2'(i >> 3); b = 2'(i >> 1); bi = 1'(i);
      e = model(2, longint'(a), longint'(b), longint'(bi));
      op2(a, b, bi, n);
      n_total++;
      if ({bout2, ovf2, diff2} !== {e[9:8], e[1:0]} || n !== 2 || diff2[0] !== (a[0] ^ b[0] ^ bi))
        $display("FAIL w2 %0d-%0d-%b got %b/%b/%0d lat %0d want %b/%b/%0d", a, b, bi, bout2, ovf2, diff2, n, e[9], e[8], e[1:0]);
      else n_pass++;
    end
  endtask

  task automatic test_protocol();
    int n, dones;
    logic [9:0] prev, e;
    op8(8'h11, 8'h22, 1'b0, n);
    prev = {bout8, ovf8, diff8};
    @(posedge clk); #1;
    e = model(8, 64'h9C, 64'h3A, 1);
    a8 = 8'h9C; b8 = 8'h3A; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); start8 = 1'(i);
      if (i == 4) begin
        n_total++; if ({bout8, ovf8, diff8} !== prev) $display("FAIL run_hold got %h want %h", {bout8, ovf8, diff8}, prev); else n_pass++;
      end
      if (done8) dones++;
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    n_total++; if ({done8, bout8, ovf8, diff8} !== {1'b1, e}) $display("FAIL captured got %b/%h want 1/%h", done8, {bout8, ovf8, diff8}, e); else n_pass++;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done8) dones++; end
    n_total++; if (dones !== 0) $display("FAIL extra_done got %0d want 0", dones); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n, first, second;
    logic [9:0] e;
    e = model(8, 64'h3C, 64'hC3, 0);
    a8 = 8'h3C; b8 = 8'hC3; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    n = 0; first = -1; second = -1;
    while (n < 40 && second < 0) begin
      @(posedge clk); #1; n++;
      if (done8) begin if (first < 0) first = n; else second = n; end
    end
    start8 = 1'b0;
    n_total++; if (first !== 8) $display("FAIL b2b_first got %0d want 8", first); else n_pass++;
    n_total++; if (second - first !== 10) $display("FAIL b2b_period got %0d want 10", second - first); else n_pass++;
    n_total++; if ({bout8, ovf8, diff8} !== e) $display("FAIL b2b_result got %h want %h", {bout8, ovf8, diff8}, e); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_total++; if (ready8 !== 1'b1) $display("FAIL b2b_idle got %b want 1", ready8); else n_pass++;
  endtask

  task automatic test_abort();
    int n, dones;
    logic [9:0] e;
    a8 = 8'hA5; b8 = 8'h17; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (ready8 !== 1'b1) $display("FAIL abort_ready got %b want 1", ready8); else n_pass++;
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (done8) dones++; end
    n_total++; if (dones !== 0) $display("FAIL abort_done got %0d want 0", dones); else n_pass++;
    n_total++; if ({bout8, ovf8, diff8} !== 10'h0) $display("FAIL abort_outputs got %h want 000", {bout8, ovf8, diff8}); else n_pass++;
    e = model(8, 64'hA5, 64'h17, 1);
    op8(8'hA5, 8'h17, 1'b1, n);
    n_total++; if ({bout8, ovf8, diff8} !== e || n !== 8) $display("FAIL abort_next got %h lat %0d want %h lat 8", {bout8, ovf8, diff8}, n, e); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_exhaustive_w2();
    test_protocol();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
